// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hard-wired Moore control unit for the single-bus datapath.
//            Sequences fetch (T0, optional memory wait, T1, T2), decodes the
//            5-bit opcode held in ir[31:27] and steps through the execute
//            cycles of each instruction class. Every control output is a
//            flop loaded from the decode of the next state, so the datapath
//            sees glitch-free enables aligned to the state they belong to.
// Ports    : clock       - system clock, rising edge
//            clear       - synchronous active-high reset (state back to T0)
//            ir          - instruction register contents from the datapath
//            con_ff_bit  - branch condition from the datapath CON flip-flop
//            IRin..Outport_in       - register load enables
//            HIout..Cout            - bus source selects (one-hot or none)
//            Gra/Grb/Grc/Rin/Rout/BAout/CONin - register-field decode controls
//            Mem_read    - MDR loads from memory data when MDRin
//            mem_write   - one-cycle RAM write strobe (addr=MAR, data=MDR)
//            opcode      - ALU operation select
//            IncPC       - ALU PC+1 mode
//            run         - high unless halted
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff_bit,
  output logic        IRin,
  output logic        PCin,
  output logic        RYin,
  output logic        RZin,
  output logic        MARin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Outport_in,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhi_out,
  output logic        Zlo_out,
  output logic        PCout,
  output logic        MDRout,
  output logic        Inport_out,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CONin,
  output logic        Mem_read,
  output logic        mem_write,
  output logic [4:0]  opcode,
  output logic        IncPC,
  output logic        run
);

  // S_CLR is the "T0 pending" state entered by clear: outputs are all zero
  // (run=1) for that cycle and the T0 fetch step follows unconditionally.
  typedef enum logic [3:0] {
    S_CLR   = 4'd0,
    S_T0    = 4'd1,
    S_FWAIT = 4'd2,
    S_T1    = 4'd3,
    S_T2    = 4'd4,
    S_T3    = 4'd5,
    S_T4    = 4'd6,
    S_T5    = 4'd7,
    S_XWAIT = 4'd8,
    S_T6    = 4'd9,
    S_T7    = 4'd10,
    S_HALT  = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    CL_LD   = 4'd0,
    CL_LDI  = 4'd1,
    CL_ST   = 4'd2,
    CL_ALU  = 4'd3,
    CL_IMM  = 4'd4,
    CL_MD   = 4'd5,
    CL_NEG  = 4'd6,
    CL_BR   = 4'd7,
    CL_JR   = 4'd8,
    CL_IN   = 4'd9,
    CL_OUT  = 4'd10,
    CL_MFHI = 4'd11,
    CL_MFLO = 4'd12,
    CL_NOP  = 4'd13,
    CL_HALT = 4'd14
  } op_class_e;

  // Control word layout: bit 0..25 single-bit controls, 30:26 opcode,
  // 31 IncPC, 32 run.
  localparam int c_opc_lsb = 26;
  localparam logic [32:0] c_irin     = 33'd1 << 0;
  localparam logic [32:0] c_pcin     = 33'd1 << 1;
  localparam logic [32:0] c_ryin     = 33'd1 << 2;
  localparam logic [32:0] c_rzin     = 33'd1 << 3;
  localparam logic [32:0] c_marin    = 33'd1 << 4;
  localparam logic [32:0] c_mdrin    = 33'd1 << 5;
  localparam logic [32:0] c_hiin     = 33'd1 << 6;
  localparam logic [32:0] c_loin     = 33'd1 << 7;
  localparam logic [32:0] c_outin    = 33'd1 << 8;
  localparam logic [32:0] c_hiout    = 33'd1 << 9;
  localparam logic [32:0] c_loout    = 33'd1 << 10;
  localparam logic [32:0] c_zhiout   = 33'd1 << 11;
  localparam logic [32:0] c_zloout   = 33'd1 << 12;
  localparam logic [32:0] c_pcout    = 33'd1 << 13;
  localparam logic [32:0] c_mdrout   = 33'd1 << 14;
  localparam logic [32:0] c_inout    = 33'd1 << 15;
  localparam logic [32:0] c_cout     = 33'd1 << 16;
  localparam logic [32:0] c_gra      = 33'd1 << 17;
  localparam logic [32:0] c_grb      = 33'd1 << 18;
  localparam logic [32:0] c_grc      = 33'd1 << 19;
  localparam logic [32:0] c_rin      = 33'd1 << 20;
  localparam logic [32:0] c_rout     = 33'd1 << 21;
  localparam logic [32:0] c_baout    = 33'd1 << 22;
  localparam logic [32:0] c_conin    = 33'd1 << 23;
  localparam logic [32:0] c_memrd    = 33'd1 << 24;
  localparam logic [32:0] c_memwr    = 33'd1 << 25;
  localparam logic [32:0] c_incpc    = 33'd1 << 31;
  localparam logic [32:0] c_run      = 33'd1 << 32;
  localparam logic [4:0]  c_op_add   = 5'b00011;

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  // Counter is loaded with MEM_WAIT-1 on entry and the wait state is left
  // when it reads zero, giving exactly MEM_WAIT idle cycles.
  localparam logic [CNT_W-1:0] c_wait_reload =
    CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]      ctl_q, ctl_d;
  op_class_e        op_cls;

  // Only the opcode field of the instruction matters to the sequencer.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:0];

  function automatic op_class_e classify(input logic [4:0] op);
    op_class_e cls;
    cls = CL_NOP;
    case (op)
      5'd0:  cls = CL_LD;
      5'd1:  cls = CL_LDI;
      5'd2:  cls = CL_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
             cls = CL_ALU;
      5'd12, 5'd13, 5'd14:
             cls = CL_IMM;
      5'd15, 5'd16:
             cls = CL_MD;
      5'd17, 5'd18:
             cls = CL_NEG;
      5'd19: cls = CL_BR;
      5'd20: cls = CL_JR;
      5'd22: cls = CL_IN;
      5'd23: cls = CL_OUT;
      5'd24: cls = CL_MFHI;
      5'd25: cls = CL_MFLO;
      5'd27: cls = CL_HALT;
      default: cls = CL_NOP;  // nop, jal and the unused 111xx codes
    endcase
    return cls;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    // The IR is valid at the end of T2; capture its opcode there so the
    // execute sequence is immune to later changes on the ir input.
    if (state_q == S_T2) begin
      op_d = ir[31:27];
    end
    op_cls = classify(op_d);

    case (state_q)
      S_CLR: state_d = S_T0;
      S_T0: begin
        if (MEM_WAIT > 0) begin
          state_d = S_FWAIT;
          cnt_d   = c_wait_reload;
        end else begin
          state_d = S_T1;
        end
      end
      S_FWAIT: begin
        if (cnt_q == '0) begin
          state_d = S_T1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = (op_cls == CL_HALT) ? S_HALT : S_T3;
      S_T3: begin
        case (op_cls)
          CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP: state_d = S_T0;
          default: state_d = S_T4;
        endcase
      end
      S_T4: state_d = (op_cls == CL_NEG) ? S_T0 : S_T5;
      S_T5: begin
        case (op_cls)
          CL_LD, CL_ST: begin
            if (MEM_WAIT > 0) begin
              state_d = S_XWAIT;
              cnt_d   = c_wait_reload;
            end else begin
              state_d = S_T6;
            end
          end
          CL_MD:   state_d = S_T6;
          // Untaken branch ends here; PC keeps the already incremented value.
          CL_BR:   state_d = con_ff_bit ? S_T6 : S_T0;
          default: state_d = S_T0;
        endcase
      end
      S_XWAIT: begin
        if (cnt_q == '0) begin
          state_d = S_T6;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_T6: state_d = ((op_cls == CL_LD) || (op_cls == CL_ST)) ? S_T7 : S_T0;
      S_T7: state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_CLR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode of the next state (registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    ctl_d = c_run;
    if ((state_d inside {S_T3, S_T4, S_T5, S_XWAIT, S_T6, S_T7}) &&
        (op_cls != CL_NOP)) begin
      ctl_d[c_opc_lsb +: 5] = op_d;
    end

    case (state_d)
      S_T0: ctl_d = ctl_d | c_pcout | c_marin | c_incpc | c_rzin;
      S_T1: ctl_d = ctl_d | c_zloout | c_pcin | c_memrd | c_mdrin;
      S_T2: ctl_d = ctl_d | c_mdrout | c_irin;
      S_T3: begin
        case (op_cls)
          CL_ALU, CL_IMM:        ctl_d = ctl_d | c_grb | c_rout | c_ryin;
          CL_NEG:                ctl_d = ctl_d | c_grb | c_rout | c_rzin;
          CL_MD:                 ctl_d = ctl_d | c_gra | c_rout | c_ryin;
          // BAout lets R0 read as zero for the base of the effective address.
          CL_LD, CL_LDI, CL_ST:  ctl_d = ctl_d | c_grb | c_rout | c_baout | c_ryin;
          CL_BR:                 ctl_d = ctl_d | c_gra | c_rout | c_conin;
          CL_JR:                 ctl_d = ctl_d | c_gra | c_rout | c_pcin;
          CL_IN:                 ctl_d = ctl_d | c_inout | c_gra | c_rin;
          CL_OUT:                ctl_d = ctl_d | c_gra | c_rout | c_outin;
          CL_MFHI:               ctl_d = ctl_d | c_hiout | c_gra | c_rin;
          CL_MFLO:               ctl_d = ctl_d | c_loout | c_gra | c_rin;
          default: ;
        endcase
      end
      S_T4: begin
        case (op_cls)
          CL_ALU: ctl_d = ctl_d | c_grc | c_rout | c_rzin;
          CL_IMM: ctl_d = ctl_d | c_cout | c_rzin;
          CL_NEG: ctl_d = ctl_d | c_zloout | c_gra | c_rin;
          CL_MD:  ctl_d = ctl_d | c_grb | c_rout | c_rzin;
          CL_LD, CL_LDI, CL_ST: begin
            // Effective address = base + C, so the ALU is forced to add.
            ctl_d = ctl_d | c_cout | c_rzin;
            ctl_d[c_opc_lsb +: 5] = c_op_add;
          end
          CL_BR:  ctl_d = ctl_d | c_pcout | c_ryin;
          default: ;
        endcase
      end
      S_T5: begin
        case (op_cls)
          CL_ALU, CL_IMM, CL_LDI: ctl_d = ctl_d | c_zloout | c_gra | c_rin;
          CL_MD:                  ctl_d = ctl_d | c_zloout | c_loin;
          CL_LD, CL_ST:           ctl_d = ctl_d | c_zloout | c_marin;
          CL_BR: begin
            // Branch target = PC + C.
            ctl_d = ctl_d | c_cout | c_rzin;
            ctl_d[c_opc_lsb +: 5] = c_op_add;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_cls)
          CL_MD: ctl_d = ctl_d | c_zhiout | c_hiin;
          CL_LD: ctl_d = ctl_d | c_memrd | c_mdrin;
          // Store data enters MDR from the bus, not from memory.
          CL_ST: ctl_d = ctl_d | c_gra | c_rout | c_mdrin;
          CL_BR: ctl_d = ctl_d | c_zloout | c_pcin;
          default: ;
        endcase
      end
      S_T7: begin
        case (op_cls)
          CL_LD: ctl_d = ctl_d | c_mdrout | c_gra | c_rin;
          CL_ST: ctl_d = ctl_d | c_memwr;
          default: ;
        endcase
      end
      S_HALT: ctl_d = '0;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_CLR;
      op_q    <= '0;
      cnt_q   <= '0;
      ctl_q   <= c_run;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign IRin       = ctl_q[0];
  assign PCin       = ctl_q[1];
  assign RYin       = ctl_q[2];
  assign RZin       = ctl_q[3];
  assign MARin      = ctl_q[4];
  assign MDRin      = ctl_q[5];
  assign HIin       = ctl_q[6];
  assign LOin       = ctl_q[7];
  assign Outport_in = ctl_q[8];
  assign HIout      = ctl_q[9];
  assign LOout      = ctl_q[10];
  assign Zhi_out    = ctl_q[11];
  assign Zlo_out    = ctl_q[12];
  assign PCout      = ctl_q[13];
  assign MDRout     = ctl_q[14];
  assign Inport_out = ctl_q[15];
  assign Cout       = ctl_q[16];
  assign Gra        = ctl_q[17];
  assign Grb        = ctl_q[18];
  assign Grc        = ctl_q[19];
  assign Rin        = ctl_q[20];
  assign Rout       = ctl_q[21];
  assign BAout      = ctl_q[22];
  assign CONin      = ctl_q[23];
  assign Mem_read   = ctl_q[24];
  assign mem_write  = ctl_q[25];
  assign opcode     = ctl_q[30:26];
  assign IncPC      = ctl_q[31];
  assign run        = ctl_q[32];

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench for control_sequencer. A reference model
//            expands each instruction into its list of per-cycle control
//            words; the stimulus process queues that list and drives ir and
//            con_ff_bit, while an independent monitor pops one expected word
//            per clock and compares it with the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  localparam int MEM_WAIT  = 2;
  localparam int FETCH_LEN = MEM_WAIT + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic [31:0] ir;
  logic        con_ff_bit;
  logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, CONin, Mem_read, mem_write;
  logic [4:0] opcode;
  logic IncPC, run;

  control_sequencer #(.MEM_WAIT(MEM_WAIT)) dut (
    .clock(clk), .clear(clear), .ir(ir), .con_ff_bit(con_ff_bit),
    .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
    .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .CONin(CONin), .Mem_read(Mem_read), .mem_write(mem_write),
    .opcode(opcode), .IncPC(IncPC), .run(run)
  );

  // Bench-side packing of the DUT outputs into one comparable word.
  logic [32:0] act;
  assign act = {run, IncPC, opcode, mem_write, Mem_read, CONin, BAout, Rout,
                Rin, Grc, Grb, Gra, Cout, Inport_out, MDRout, PCout, Zlo_out,
                Zhi_out, LOout, HIout, Outport_in, LOin, HIin, MDRin, MARin,
                RZin, RYin, PCin, IRin};

  localparam logic [32:0] IRIN  = 33'd1 << 0;
  localparam logic [32:0] PCIN  = 33'd1 << 1;
  localparam logic [32:0] RYIN  = 33'd1 << 2;
  localparam logic [32:0] RZIN  = 33'd1 << 3;
  localparam logic [32:0] MARIN = 33'd1 << 4;
  localparam logic [32:0] MDRIN = 33'd1 << 5;
  localparam logic [32:0] HIIN  = 33'd1 << 6;
  localparam logic [32:0] LOIN  = 33'd1 << 7;
  localparam logic [32:0] OUTIN = 33'd1 << 8;
  localparam logic [32:0] HIOUT = 33'd1 << 9;
  localparam logic [32:0] LOOUT = 33'd1 << 10;
  localparam logic [32:0] ZHI   = 33'd1 << 11;
  localparam logic [32:0] ZLO   = 33'd1 << 12;
  localparam logic [32:0] PCOUT = 33'd1 << 13;
  localparam logic [32:0] MDROUT= 33'd1 << 14;
  localparam logic [32:0] INOUT = 33'd1 << 15;
  localparam logic [32:0] COUT  = 33'd1 << 16;
  localparam logic [32:0] GRA   = 33'd1 << 17;
  localparam logic [32:0] GRB   = 33'd1 << 18;
  localparam logic [32:0] GRC   = 33'd1 << 19;
  localparam logic [32:0] RIN   = 33'd1 << 20;
  localparam logic [32:0] ROUT  = 33'd1 << 21;
  localparam logic [32:0] BAOUT = 33'd1 << 22;
  localparam logic [32:0] CONIN = 33'd1 << 23;
  localparam logic [32:0] MRD   = 33'd1 << 24;
  localparam logic [32:0] MWR   = 33'd1 << 25;
  localparam logic [32:0] INCPC = 33'd1 << 31;
  localparam logic [32:0] RUN   = 33'd1 << 32;
  localparam logic [4:0]  ADD   = 5'b00011;

  logic [32:0] exp_q[$];
  string       tag_q[$];
  logic [32:0] seq_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        running  = 1'b0;
  logic        stim_done = 1'b0;

  // One control word of a running machine: mask + opcode field + run.
  function automatic logic [32:0] st(input logic [32:0] m, input logic [4:0] opc);
    return m | RUN | ({28'd0, opc} << 26);
  endfunction

  // Reference model: the full per-cycle control sequence of one instruction.
  task automatic model(input logic [4:0] o, input logic c);
    seq_q.delete();
    seq_q.push_back(st(PCOUT | MARIN | INCPC | RZIN, 5'd0));
    repeat (MEM_WAIT) seq_q.push_back(st('0, 5'd0));
    seq_q.push_back(st(ZLO | PCIN | MRD | MDRIN, 5'd0));
    seq_q.push_back(st(MDROUT | IRIN, 5'd0));
    if (o <= 5'd2) begin
      seq_q.push_back(st(GRB | ROUT | BAOUT | RYIN, o));
      seq_q.push_back(st(COUT | RZIN, ADD));
      if (o == 5'd1) begin
        seq_q.push_back(st(ZLO | GRA | RIN, o));
      end else begin
        seq_q.push_back(st(ZLO | MARIN, o));
        repeat (MEM_WAIT) seq_q.push_back(st('0, o));
        if (o == 5'd0) begin
          seq_q.push_back(st(MRD | MDRIN, o));
          seq_q.push_back(st(MDROUT | GRA | RIN, o));
        end else begin
          seq_q.push_back(st(GRA | ROUT | MDRIN, o));
          seq_q.push_back(st(MWR, o));
        end
      end
    end else if (o <= 5'd11) begin
      seq_q.push_back(st(GRB | ROUT | RYIN, o));
      seq_q.push_back(st(GRC | ROUT | RZIN, o));
      seq_q.push_back(st(ZLO | GRA | RIN, o));
    end else if (o <= 5'd14) begin
      seq_q.push_back(st(GRB | ROUT | RYIN, o));
      seq_q.push_back(st(COUT | RZIN, o));
      seq_q.push_back(st(ZLO | GRA | RIN, o));
    end else if (o <= 5'd16) begin
      seq_q.push_back(st(GRA | ROUT | RYIN, o));
      seq_q.push_back(st(GRB | ROUT | RZIN, o));
      seq_q.push_back(st(ZLO | LOIN, o));
      seq_q.push_back(st(ZHI | HIIN, o));
    end else if (o <= 5'd18) begin
      seq_q.push_back(st(GRB | ROUT | RZIN, o));
      seq_q.push_back(st(ZLO | GRA | RIN, o));
    end else if (o == 5'd19) begin
      seq_q.push_back(st(GRA | ROUT | CONIN, o));
      seq_q.push_back(st(PCOUT | RYIN, o));
      seq_q.push_back(st(COUT | RZIN, ADD));
      if (c) seq_q.push_back(st(ZLO | PCIN, o));
    end else if (o == 5'd20) seq_q.push_back(st(GRA | ROUT | PCIN, o));
    else if (o == 5'd22) seq_q.push_back(st(INOUT | GRA | RIN, o));
    else if (o == 5'd23) seq_q.push_back(st(GRA | ROUT | OUTIN, o));
    else if (o == 5'd24) seq_q.push_back(st(HIOUT | GRA | RIN, o));
    else if (o == 5'd25) seq_q.push_back(st(LOOUT | GRA | RIN, o));
    else if (o == 5'd27) repeat (21) seq_q.push_back('0);
    else seq_q.push_back(st('0, 5'd0));
  endtask

  // Called at the start of the instruction's T0 cycle. abort_idx >= 0 asserts
  // clear during that cycle of the sequence.
  task automatic run_instr(input logic [31:0] instr, input logic c, input int abort_idx);
    int n;
    model(instr[31:27], c);
    n = (abort_idx >= 0 && abort_idx < seq_q.size()) ? abort_idx + 1 : seq_q.size();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(seq_q[i]);
      tag_q.push_back($sformatf("op%0d.c%0d", instr[31:27], i));
    end
    for (int i = 0; i < n; i++) begin
      if (i == MEM_WAIT + 2) begin
        ir = instr;
        con_ff_bit = c;
      end
      if (i == abort_idx) clear = 1'b1;
      @(posedge clk); #1;
    end
    if (abort_idx >= 0) begin
      exp_q.push_back(RUN);
      tag_q.push_back("after_clear");
      clear = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Stimulus
  initial begin
    logic [4:0] o;
    int ab;
    clear = 1'b1;
    ir = '0;
    con_ff_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    running = 1'b1;
    exp_q.push_back(RUN);
    tag_q.push_back("reset");
    clear = 1'b0;
    @(posedge clk); #1;

    run_instr(32'h19880000, 1'b0, -1);           // add R3,R1,R2
    run_instr(32'h10800055, 1'b0, -1);           // st
    run_instr({5'd19, 27'h0000123}, 1'b0, -1);   // br not taken
    run_instr({5'd19, 27'h0000456}, 1'b1, -1);   // br taken
    run_instr(32'h80880000, 1'b0, -1);           // mul
    run_instr({5'd0, 27'h0000789}, 1'b0, FETCH_LEN + 2);  // ld cleared in T5
    for (int k = 0; k < 60; k++) begin
      do o = 5'($urandom_range(0, 31)); while (o == 5'd27);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, FETCH_LEN)) : -1;
      run_instr({o, 27'($urandom)}, 1'($urandom_range(0, 1)), ab);
    end
    run_instr(32'hD8000000, 1'b0, FETCH_LEN + 20); // halt, then clear
    run_instr(32'h19880000, 1'b0, -1);
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic [32:0] e;
    string t;
    forever begin
      @(negedge clk);
      if (stim_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL leftover: got %0d queued words, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (running) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL underflow: got output %h with no expected word", act);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", t, act, e);
          end
        end
        checks++;
        if ($countones({Rout, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout,
                        Inport_out, Cout}) > 1) begin
          failures++;
          $display("FAIL bus_onehot: got %h expected at most one bus source", act);
        end
        checks++;
        if (mem_write && MDRin) begin
          failures++;
          $display("FAIL wr_vs_mdrin: got mem_write=1 MDRin=1 expected not both");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hard-wired Moore control unit that drives every control input of the datapath from the IR and con_ff_bit it returns.
- Sequences fetch, decode and execute steps for the 5-bit opcode set.
- Sits beside the datapath; its outputs connect one-to-one to the datapath's enable, bus-select, memory and Gra/Grb/Grc ports.

Parameters:
- MEM_WAIT, 0, idle cycles inserted after MARin before any Mem_read/MDRin or mem_write step.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  synchronous, active-high reset.
- ir  input  32  IR contents; opcode is ir[31:27].
- con_ff_bit  input  1  branch condition from datapath CON FF.
- IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in  output  1 each  register enables.
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  output  1 each  bus source selects.
- Gra, Grb, Grc, Rin, Rout, BAout, CONin  output  1 each  register-field select/decode controls.
- Mem_read  output  1  MDR loads from memory data when MDRin.
- mem_write  output  1  one-cycle RAM write strobe (address=MAR, data=MDR).
- opcode  output  5  ALU operation.
- IncPC  output  1  ALU PC+1 mode.
- run  output  1  high unless halted.

Behaviour:
- All outputs registered, decoded from next state. On clear (any state, mid-instruction included): state=T0, every output 0 except run=1. Aborted instruction leaves no further effects.
- Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - addi 01100, andi 01101, ori 01110
  - div 01111, mul 10000, neg 10001, not 10010
  - br 10011, jr 10100, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011
  - jal 10101 and 11100-11111 execute as nop.
- Fetch:
  - T0: PCout MARin IncPC RZin, opcode=00000.
  - Then MEM_WAIT idle cycles.
  - T1: Zlo_out PCin Mem_read MDRin.
  - T2: MDRout IRin.
  - Decode occurs on the T2->T3 transition from the newly loaded ir.
- opcode output = ir[31:27] in execute states, forced to 00011 (add) in address-compute states.
- Execute sequences (the final listed step returns to T0):
  - R-type ALU: T3 Grb Rout RYin; T4 Grc Rout RZin; T5 Zlo_out Gra Rin.
  - Immediate ALU: as R-type, with T4 Cout replacing Grc Rout.
  - neg/not: T3 Grb Rout RZin; T4 Zlo_out Gra Rin.
  - mul/div: T3 Gra Rout RYin; T4 Grb Rout RZin; T5 Zlo_out LOin; T6 Zhi_out HIin.
  - ldi: T3 Grb Rout BAout RYin; T4 Cout RZin; T5 Zlo_out Gra Rin.
  - ld: ldi T3-T4; T5 Zlo_out MARin; MEM_WAIT idles; T6 Mem_read MDRin; T7 MDRout Gra Rin.
  - st: ld T3-T5 and idles; T6 Gra Rout MDRin (Mem_read=0); T7 mem_write.
  - br: T3 Gra Rout CONin; T4 PCout RYin; T5 Cout RZin; T6 Zlo_out PCin only if con_ff_bit=1. If 0, T5 returns to T0 and PC is unchanged.
  - jr: T3 Gra Rout PCin.
  - in: T3 Inport_out Gra Rin.
  - out: T3 Gra Rout Outport_in.
  - mfhi: T3 HIout Gra Rin.
  - mflo: T3 LOout Gra Rin.
  - nop: T3 no outputs.
- halt: enter HALTED; all outputs 0, run=0; exit only via clear.
- Invariants, checked each cycle:
  - At most one bus source active. Rout, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out and Cout are mutually exclusive.
  - mem_write never coincides with MDRin.
  - Wait counter reloads to MEM_WAIT on each entry.

Test Plan:
- Clear asserted mid-ld (state T5) -> next cycle all outputs 0, run=1; following cycle PCout=MARin=IncPC=RZin=1.
- MEM_WAIT=2, add R3,R1,R2 (ir=0x19880000) -> T0, 2 idle cycles, then T1, T2, then T3 Grb/Rout/RYin, T4 Grc/Rout/RZin/opcode=00011, T5 Zlo_out/Gra/Rin; 8 cycles total.
- st (ir=0x10800055), MEM_WAIT=1 -> Cout at T4 with opcode=00011; MARin at T5; one idle; MDRin with Mem_read=0; mem_write pulses exactly 1 cycle.
- br with con_ff_bit=0 vs 1 -> 0: return to T0 after T5, no PCin. 1: T6 asserts Zlo_out+PCin.
- mul (ir=0x80880000) -> LOin with Zlo_out, then HIin with Zhi_out in consecutive cycles; RZin exactly once.
- halt (ir=0xD8000000) -> run=0 and all outputs 0 held for 20 cycles; clear -> T0 fetch resumes.
